// File: rtl/store_size_unit_pkg.sv
// Store-size encodings and FSM state encodings shared with the control unit,
// plus a small word-alignment helper.
package store_size_unit_pkg;

  typedef enum logic [1:0] {
    SZ_W   = 2'd0,
    SZ_H   = 2'd1,
    SZ_B   = 2'd2,
    SZ_RSV = 2'd3
  } store_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/store_size_unit_if.sv
// Request, completion and memory-port signals of the store path.
// The misalign flag exists only when STORE_ALIGN_CHECK_EN is defined.
// Handshake: start is a one-cycle request honoured only while busy=0; done
// pulses for one cycle when the store has finished; mem_wr is the single write strobe.
interface store_size_unit_if;
  import store_size_unit_pkg::*;

  logic        start;
  logic [1:0]  StoreSize;
  logic [31:0] Address;
  logic [31:0] RegData;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        busy;
  logic        done;
  state_e      state_dbg;
`ifdef STORE_ALIGN_CHECK_EN
  logic        misalign;
`endif

  modport master (
    output start, StoreSize, Address, RegData, mem_rdata,
    input  mem_addr, mem_wdata, mem_wr, busy, done, state_dbg
`ifdef STORE_ALIGN_CHECK_EN
    , input misalign
`endif
  );

  modport slave (
    input  start, StoreSize, Address, RegData, mem_rdata,
    output mem_addr, mem_wdata, mem_wr, busy, done, state_dbg
`ifdef STORE_ALIGN_CHECK_EN
    , output misalign
`endif
  );

endinterface

// File: rtl/store_size_unit_byte_merge.sv
// Combinational lane merge for sub-word stores: overlays the halfword or byte
// of register data onto the old memory word, little-endian lanes.
module store_byte_merge
  import store_size_unit_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [15:0] reg_lo,
  input  store_size_e size,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    case (size)
      SZ_H: begin
        if (addr_lo[1]) merged[31:16] = reg_lo;
        else            merged[15:0]  = reg_lo;
      end
      SZ_B: merged[{addr_lo, 3'b000} +: 8] = reg_lo[7:0];
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_size_unit.sv
// Multicycle store unit: sw writes directly, sh/sb read-modify-write.
// Define STORE_ALIGN_CHECK_EN to flag misaligned sw/sh via misalign instead of storing.
module store_size_unit
  import store_size_unit_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  store_size_unit_if.slave bus
);

  localparam logic [2:0] CNT_LAST = 3'(MEM_LATENCY - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] old_q, old_d;
  store_size_e size_q, size_d;
  logic [31:0] merged;

`ifdef STORE_ALIGN_CHECK_EN
  logic mis_q, mis_d, mis_req;
  assign mis_req = ((bus.StoreSize == SZ_H) && bus.Address[0]) ||
                   ((bus.StoreSize == SZ_W) && (bus.Address[1:0] != 2'b00));
`endif

  store_byte_merge u_merge (
    .old_word (old_q),
    .reg_lo   (data_q[15:0]),
    .size     (size_q),
    .addr_lo  (addr_q[1:0]),
    .merged   (merged)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    old_d   = old_q;
    size_d  = size_q;
`ifdef STORE_ALIGN_CHECK_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          addr_d = bus.Address;
          data_d = bus.RegData;
          size_d = store_size_e'(bus.StoreSize);
          cnt_d  = 3'd0;
          case (store_size_e'(bus.StoreSize))
            SZ_W:       state_d = ST_WRITE;
            SZ_H, SZ_B: state_d = ST_READ;
            default:    state_d = ST_DONE;
          endcase
`ifdef STORE_ALIGN_CHECK_EN
          mis_d = mis_req;
          if (mis_req) state_d = ST_DONE;
`endif
        end
      end
      ST_READ: begin
        // Read data is valid only on the last of MEM_LATENCY read cycles.
        if (cnt_q == CNT_LAST) begin
          old_d   = bus.mem_rdata;
          cnt_d   = 3'd0;
          state_d = ST_WRITE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_WRITE: state_d = ST_DONE;
      default: begin
        state_d = ST_IDLE;
`ifdef STORE_ALIGN_CHECK_EN
        mis_d   = 1'b0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      old_q   <= 32'd0;
      size_q  <= SZ_W;
`ifdef STORE_ALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      old_q   <= old_d;
      size_q  <= size_d;
`ifdef STORE_ALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  // Outputs decode directly from the state flop so reset clears them asynchronously.
  assign bus.state_dbg = state_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.mem_wr    = (state_q == ST_WRITE);
  assign bus.mem_addr  = (state_q != ST_IDLE) ? word_addr(addr_q) : 32'd0;
  assign bus.mem_wdata = (state_q != ST_WRITE) ? 32'd0 :
                         (size_q == SZ_W)      ? data_q : merged;
`ifdef STORE_ALIGN_CHECK_EN
  assign bus.misalign  = (state_q == ST_DONE) && mis_q;
`endif

endmodule

// File: doc/store_size_unit.md
# store_size_unit

Multicycle store path of the CPU: the register-bank to memory direction. On `start` it writes a register value to byte-addressed memory as a word, halfword or byte. For `sh`/`sb` it does a read-modify-write so the untouched byte lanes keep their old contents. It sits between register B / ALUOut and the memory port and is sequenced by the control unit through `start`/`done`.

## Interface
Parameters:
- MEM_LATENCY, 1, cycles from `mem_addr` presented (with `mem_wr`=0) to `mem_rdata` valid; legal range 1..7.

Ports (clock and reset first):
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  one-cycle request, sampled only in IDLE
- StoreSize  input  2  0=sw, 1=sh, 2=sb, 3=reserved
- Address  input  32  byte address (ALUOut)
- RegData  input  32  value to store (register B)
- mem_rdata  input  32  memory read data
- mem_addr  output  32  word address: captured `Address` with bits [1:0] cleared
- mem_wdata  output  32  merged write word
- mem_wr  output  1  memory write strobe, high exactly one cycle per store
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- misalign  output  1  present only with `STORE_ALIGN_CHECK_EN`; see Configuration

## Operation
- Memory byte order is little-endian: byte lane k = bits [8k+7:8k].
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: when `start`=1, capture `Address`, `RegData` and `StoreSize`.
  - sw goes to WRITE.
  - sh/sb go to READ.
  - reserved size goes to DONE with no memory access.
- READ:
  - Drive `mem_addr`; keep `mem_wr`=0.
  - Stay MEM_LATENCY cycles using a 3-bit counter.
  - On the last READ cycle, latch `mem_rdata` into the old-word register, then go to WRITE.
- WRITE: `mem_wr`=1 and `mem_wdata` = merged word; go to DONE.
  - sw: merged word = RegData.
  - sh: RegData[15:0] replaces lane pair addr[1]; the other halfword is kept from the old word.
  - sb: RegData[7:0] replaces lane addr[1:0]; the other three bytes are kept.
- DONE: `done`=1; go to IDLE.
- `start` outside IDLE is ignored; no queueing.
- Inputs other than `mem_rdata` are don't-care after capture.

## Timing
- Cycle 0 is the edge at which `start` is sampled in IDLE.
- sw: WRITE in cycle 1, `done` in cycle 2, IDLE (can accept `start`) in cycle 3.
- sh/sb:
  - READ in cycles 1..MEM_LATENCY.
  - WRITE in cycle MEM_LATENCY+1.
  - `done` in cycle MEM_LATENCY+2.
  - With MEM_LATENCY=1: write in cycle 2, `done` in cycle 3.
- `mem_addr` holds the captured word address from READ through DONE and is 0 in IDLE.
- `mem_wdata` is 0 outside WRITE.
- Reset values: state IDLE, counter 0, captured registers 0; all outputs (`mem_addr`, `mem_wdata`, `mem_wr`, `busy`, `done`, `misalign`) 0.
- Reset mid-operation: `mem_wr` and `busy` drop asynchronously. A store aborted before WRITE produces no write. No `done` is issued.
- `done` and a new `start` in the same cycle: the `start` is ignored, because the FSM is not yet in IDLE.

## Configuration
- Macro `STORE_ALIGN_CHECK_EN`.
- Defined:
  - sh with addr[0]=1, or sw with addr[1:0]≠0, skips READ/WRITE.
  - It goes straight to DONE in cycle 1, with `done`=1 and `misalign`=1 in that same cycle; no memory access occurs.
  - `misalign` is 0 at all other times.
  - The control unit uses it to raise the alignment exception.
- Undefined:
  - The `misalign` port and its logic are absent.
  - Low address bits are ignored as stated above: sw forces word alignment, and sh uses addr[1] only.

## Structure
- Shared package/header `cpu_defs`: StoreSize encodings (SZ_W=0, SZ_H=1, SZ_B=2) and FSM state localparams, shared with the control unit.
- Sub-module `store_byte_merge`: combinational; inputs old word, RegData[15:0], size, addr[1:0]; output merged word. It is instantiated once, and the control FSM stays in the parent.

## Test plan
- sw, Address=0x0000_0104, RegData=0xDEAD_BEEF -> cycle 1 `mem_wr`=1, `mem_addr`=0x104, `mem_wdata`=0xDEADBEEF; `done` in cycle 2.
- sb, Address=0x0000_0102, RegData=0x0000_00AB, old word 0x1122_3344, MEM_LATENCY=1 -> `mem_wdata`=0x11AB_3344 in cycle 2; `done` in cycle 3.
- sh, Address=0x0000_0102, RegData=0x0000_CAFE, old word 0x1122_3344, MEM_LATENCY=3 -> `mem_wdata`=0xCAFE_3344 in cycle 4; `done` in cycle 5.
- Reset asserted during READ of an sb -> `mem_wr` never rises, `busy`=0 immediately. A following sw completes normally.
- `start` pulsed again while busy, with a different address -> ignored; exactly one `mem_wr`, at the first address.
- With `STORE_ALIGN_CHECK_EN`: sw, Address=0x0000_0106 -> `done`=1 and `misalign`=1 in cycle 1, `mem_wr` stays 0. Without the macro, the same stimulus writes to 0x104.
